uart_frame_parser: RTL and testbench

Byte-level frame parser between the UART bit receiver and the dual-port packet memory. It takes a stream of received bytes and extracts the command and length header. It writes the payload into the RX buffer at addresses 0..LEN-1, optionally verifies an XOR checksum, and signals the main control block with a one-cycle `rx_done` pulse carrying stable `cmd_rx`/`len_rx`.

---
 rtl/uart_frame_parser.sv | 165 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Frame parser: CMD, LEN, LEN payload bytes [, CHK] -> RX buffer writes plus a rx_done/rx_error pulse.
// Optional trailing XOR checksum byte is enabled by defining RX_CHECKSUM_EN.
module uart_frame_parser #(
    parameter int CLOCK   = 50_000_000,
    parameter int BAUD    = 115_200,
    parameter int NUMBER  = 256,
    parameter int TIMEOUT = 10,
    localparam int ADDR_W = $clog2(NUMBER)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              rx_err,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              we,
    output logic [7:0]        cmd_rx,
    output logic [ADDR_W-1:0] len_rx,
    output logic              rx_done,
    output logic              rx_error
);

    // Inter-byte gap limit in clocks; 64-bit math since TIMEOUT*10*CLOCK overflows 32 bits.
    localparam longint TMO_CYC = (longint'(TIMEOUT) * 10 * longint'(CLOCK)) / longint'(BAUD);
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

`ifdef RX_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE} state_t;
    localparam state_t S_TAIL = S_CHK;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE} state_t;
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t              r_state;
    logic [7:0]          r_cmd;
    logic [ADDR_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_cnt;
    logic [TMO_W-1:0]    r_tmo;
`ifdef RX_CHECKSUM_EN
    logic [7:0]          r_xor;
`endif
    logic [7:0]          r_wr_data;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_we;
    logic [7:0]          r_cmd_rx;
    logic [ADDR_W-1:0]   r_len_rx;
    logic                r_rx_done;
    logic                r_rx_error;

    logic [ADDR_W-1:0]   w_len;
    logic                w_len_bad;
    logic                w_last;
    logic                w_tmo_hit;

    assign w_len     = ADDR_W'(rx_byte);
    assign w_len_bad = (32'(rx_byte) > 32'(NUMBER - 1));
    assign w_last    = (({1'b0, r_cnt} + (ADDR_W+1)'(1)) == {1'b0, r_len});
    assign w_tmo_hit = (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cmd      <= 8'h00;
            r_len      <= '0;
            r_cnt      <= '0;
            r_tmo      <= '0;
`ifdef RX_CHECKSUM_EN
            r_xor      <= 8'h00;
`endif
            r_wr_data  <= 8'h00;
            r_wr_addr  <= '0;
            r_we       <= 1'b0;
            r_cmd_rx   <= 8'h00;
            r_len_rx   <= '0;
            r_rx_done  <= 1'b0;
            r_rx_error <= 1'b0;
        end else begin
            r_we       <= 1'b0;
            r_rx_done  <= 1'b0;
            r_rx_error <= 1'b0;
            case (r_state)
                // DONE publishes the frame and also accepts the next CMD byte, like IDLE.
                S_IDLE, S_DONE: begin
                    r_tmo <= '0;
                    if (r_state == S_DONE) begin
                        r_cmd_rx  <= r_cmd;
                        r_len_rx  <= r_len;
                        r_rx_done <= 1'b1;
                    end
                    if (rx_valid && !rx_err) begin
                        r_cmd   <= rx_byte;
                        r_state <= S_LEN;
`ifdef RX_CHECKSUM_EN
                        r_xor   <= rx_byte;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    if (rx_err) begin
                        r_state    <= S_IDLE;
                        r_rx_error <= 1'b1;
                    end else if (rx_valid) begin
                        r_tmo <= '0;
`ifdef RX_CHECKSUM_EN
                        r_xor <= r_xor ^ rx_byte;
`endif
                        case (r_state)
                            S_LEN: begin
                                r_cnt <= '0;
                                r_len <= w_len;
                                if (w_len_bad) begin
                                    r_state    <= S_IDLE;
                                    r_rx_error <= 1'b1;
                                end else if (w_len == '0) begin
                                    r_state <= S_TAIL;
                                end else begin
                                    r_state <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                r_we      <= 1'b1;
                                r_wr_data <= rx_byte;
                                r_wr_addr <= r_cnt;
                                r_cnt     <= r_cnt + ADDR_W'(1);
                                if (w_last) begin
                                    r_state <= S_TAIL;
                                end
                            end
`ifdef RX_CHECKSUM_EN
                            S_CHK: begin
                                if (rx_byte == r_xor) begin
                                    r_state <= S_DONE;
                                end else begin
                                    r_state    <= S_IDLE;
                                    r_rx_error <= 1'b1;
                                end
                            end
`endif
                            default: r_state <= S_IDLE;
                        endcase
                    end else if (w_tmo_hit) begin
                        r_state    <= S_IDLE;
                        r_rx_error <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
            endcase
        end
    end

    assign wr_data  = r_wr_data;
    assign wr_addr  = r_wr_addr;
    assign we       = r_we;
    assign cmd_rx   = r_cmd_rx;
    assign len_rx   = r_len_rx;
    assign rx_done  = r_rx_done;
    assign rx_error = r_rx_error;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: stimulus queues expected writes, done and error pulses,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_uart_frame_parser;
    localparam int NUMBER = 16;
    localparam int ADDR_W = $clog2(NUMBER);
    localparam int TMO    = 1000;   // 10 byte times of 100 clocks each

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b0;
    logic [7:0]        rx_byte  = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_err   = 1'b0;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              we;
    logic [7:0]        cmd_rx;
    logic [ADDR_W-1:0] len_rx;
    logic              rx_done;
    logic              rx_error;

    uart_frame_parser #(
        .CLOCK(1_000_000), .BAUD(100_000), .NUMBER(NUMBER), .TIMEOUT(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
        .wr_data(wr_data), .wr_addr(wr_addr), .we(we), .cmd_rx(cmd_rx), .len_rx(len_rx),
        .rx_done(rx_done), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int cmd;  int len;  int cyc; } dn_t;
    typedef struct { int lo;   int hi; } er_t;

    wr_t wq[$];
    dn_t dq[$];
    er_t eq[$];

    int checks = 0;
    int errors = 0;
    int last_cyc = 0;
    logic [7:0] pl [16];

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic monitor();
        wr_t w;
        dn_t d;
        er_t e;
        forever begin
            @(negedge clk);
            if (we !== 1'b0) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stray_we got addr=%0d data=0x%02h at cyc %0d want none", wr_addr, wr_data, cyc);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", int'(wr_addr), w.addr);
                    check("wr_data", int'(wr_data), w.data);
                    check("wr_cycle", cyc, w.cyc);
                end
            end
            if (rx_done !== 1'b0) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stray_rx_done got cmd=0x%02h len=%0d at cyc %0d want none", cmd_rx, len_rx, cyc);
                end else begin
                    d = dq.pop_front();
                    check("done_cmd", int'(cmd_rx), d.cmd);
                    check("done_len", int'(len_rx), d.len);
                    check("done_cycle", cyc, d.cyc);
                end
            end
            if (rx_error !== 1'b0) begin
                if (eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stray_rx_error got pulse at cyc %0d want none", cyc);
                end else begin
                    e = eq.pop_front();
                    checks++;
                    if (cyc < e.lo || cyc > e.hi) begin
                        errors++;
                        $display("FAIL err_cycle got=%0d want %0d..%0d", cyc, e.lo, e.hi);
                    end
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; the byte is sampled on the next edge.
    task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
        rx_byte  = b;
        rx_valid = 1'b1;
        rx_err   = err;
        last_cyc = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic send_data(input int addr, input logic [7:0] b);
        wq.push_back('{addr, int'(b), cyc + 1});
        send_byte(b);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                              input logic [7:0] chk, input bit bad);
        bit good;
        good = 1'b1;
        send_byte(cmd);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) send_data(i, pl[i]);
`ifdef RX_CHECKSUM_EN
        send_byte(chk ^ {7'd0, bad});
        good = !bad;
`endif
        if (good) dq.push_back('{int'(cmd), int'(len), last_cyc + 2});
        else      eq.push_back('{last_cyc + 1, last_cyc + 1});
    endtask

    task automatic drain(input string name);
        tick(4);
        checks++;
        if (wq.size() != 0 || dq.size() != 0 || eq.size() != 0) begin
            errors++;
            $display("FAIL %s pending got writes=%0d done=%0d err=%0d want 0 0 0",
                     name, wq.size(), dq.size(), eq.size());
            wq.delete(); dq.delete(); eq.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},       int'(we),       0);
        check({tag, "_rx_done"},  int'(rx_done),  0);
        check({tag, "_rx_error"}, int'(rx_error), 0);
        check({tag, "_wr_data"},  int'(wr_data),  0);
        check({tag, "_wr_addr"},  int'(wr_addr),  0);
        check({tag, "_cmd_rx"},   int'(cmd_rx),   0);
        check({tag, "_len_rx"},   int'(len_rx),   0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick(2);

        // Good frame
        pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
        send_frame(8'h11, 8'd3, 8'hCF, 1'b0);
        tick(3);
        check("f1_cmd_rx", int'(cmd_rx), 8'h11);
        check("f1_len_rx", int'(len_rx), 3);
        drain("good_frame");

        // Corrupted checksum, same frame and a distinct one
        send_frame(8'h11, 8'd3, 8'hCF, 1'b1);
        drain("bad_chk_same");
        pl[0] = 8'h44;
        send_frame(8'h22, 8'd1, 8'h67, 1'b1);
        tick(3);
`ifdef RX_CHECKSUM_EN
        check("badchk_cmd_kept", int'(cmd_rx), 8'h11);
        check("badchk_len_kept", int'(len_rx), 3);
`else
        check("nochk_cmd", int'(cmd_rx), 8'h22);
        check("nochk_len", int'(len_rx), 1);
`endif
        drain("bad_chk");

        // Empty payload
        send_frame(8'h05, 8'd0, 8'h05, 1'b0);
        tick(3);
        check("len0_cmd_rx", int'(cmd_rx), 8'h05);
        check("len0_len_rx", int'(len_rx), 0);
        drain("len0");

        // LEN beyond buffer depth (NUMBER-1 = 15)
        send_byte(8'h12);
        send_byte(8'h10);
        eq.push_back('{last_cyc + 1, last_cyc + 1});
        send_byte(8'h13);
        send_byte(8'hFF);
        eq.push_back('{last_cyc + 1, last_cyc + 1});
        tick(2);
        check("lenbad_cmd_kept", int'(cmd_rx), 8'h05);
        drain("len_too_big");

        // Timeout mid-DATA
        send_byte(8'h20);
        send_byte(8'h04);
        send_data(0, 8'h01);
        check("inprog_cmd_kept", int'(cmd_rx), 8'h05);
        check("inprog_len_kept", int'(len_rx), 0);
        send_data(1, 8'h02);
        eq.push_back('{last_cyc + 1 + TMO - 5, last_cyc + 1 + TMO + 5});
        tick(TMO + 50);
        drain("timeout");

        // Slow but in-time frame after the timeout
        send_byte(8'h33);
        send_byte(8'h02);
        send_data(0, 8'h10);
        tick(950);
        send_data(1, 8'h20);
`ifdef RX_CHECKSUM_EN
        tick(950);
        send_byte(8'h01);
`endif
        dq.push_back('{8'h33, 2, last_cyc + 2});
        tick(3);
        check("slow_cmd_rx", int'(cmd_rx), 8'h33);
        check("slow_len_rx", int'(len_rx), 2);
        drain("slow_frame");

        // rx_err in IDLE is ignored
        rx_err = 1'b1;
        tick(1);
        rx_err = 1'b0;
        drain("idle_rx_err");

        // rx_err together with a payload byte: error, byte dropped
        send_byte(8'h44);
        send_byte(8'h03);
        send_data(0, 8'h55);
        send_byte(8'h66, 1'b1);
        eq.push_back('{last_cyc + 1, last_cyc + 1});
        tick(3);
        check("rxerr_cmd_kept", int'(cmd_rx), 8'h33);
        check("rxerr_len_kept", int'(len_rx), 2);
        drain("rx_err_data");

        // Reset mid-DATA
        send_byte(8'h77);
        send_byte(8'h04);
        send_data(0, 8'h01);
        tick(2);
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick(20);
        check("postrst_cmd_rx", int'(cmd_rx), 0);
        drain("mid_reset");

        // Back-to-back frames, next CMD lands in the DONE cycle
        pl[0] = 8'h99;
        send_frame(8'h5A, 8'd1, 8'hC2, 1'b0);
        pl[0] = 8'h01; pl[1] = 8'h02;
        send_frame(8'hA5, 8'd2, 8'hA4, 1'b0);
        tick(3);
        check("b2b_cmd_rx", int'(cmd_rx), 8'hA5);
        check("b2b_len_rx", int'(len_rx), 2);
        drain("back_to_back");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
